// File: rtl/pin_entry_keypad.sv
// pin_entry_keypad: gathers a 4-digit BCD PIN from debounced keypad strobes and checks it
// against the account PIN, so the ATM controller only ever sees a complete entry.
module pin_entry_keypad #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_present,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] stored_pin,
    output logic        pin_entered,
    output logic        pin_correct,
    output logic [2:0]  digit_count,
    output logic        key_error,
    output logic        entry_timeout,
    output logic        entry_cancelled,
    output logic        entry_active
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          correct_q, correct_d;
    logic          entered_q, entered_d;
    logic          err_q, err_d;
    logic          tout_q, tout_d;
    logic          cancel_q, cancel_d;
    logic          active_q;
    logic          is_digit, is_clear, is_enter, is_cancel;

    assign is_digit  = key_code <= 4'd9;
    assign is_clear  = key_code == 4'hA;
    assign is_enter  = key_code == 4'hB;
    assign is_cancel = key_code == 4'hC;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        correct_d = correct_q;
        entered_d = 1'b0;
        err_d     = 1'b0;
        tout_d    = 1'b0;
        cancel_d  = 1'b0;
        // Card removal overrides any key in the same cycle and raises no pulse.
        if (!card_present) begin
            state_d   = IDLE;
            buf_d     = '0;
            cnt_d     = '0;
            tmr_d     = '0;
            correct_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = COLLECT;
                end
                COLLECT: begin
                    tmr_d = tmr_q + 1'b1;
                    if (key_valid) begin
                        tmr_d = '0;
                        if (is_digit) begin
                            if (cnt_q == 3'd4) begin
                                err_d = 1'b1;
                            end else begin
                                buf_d = {buf_q[11:0], key_code};
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else if (is_clear) begin
                            buf_d = '0;
                            cnt_d = '0;
                        end else if (is_enter) begin
                            if (cnt_q == 3'd4) begin
                                entered_d = 1'b1;
                                correct_d = buf_q == stored_pin;
                                state_d   = HOLD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (is_cancel) begin
                            buf_d    = '0;
                            cnt_d    = '0;
                            cancel_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (tmr_q == T_LAST) begin
                        tout_d = 1'b1;
                        buf_d  = '0;
                        cnt_d  = '0;
                        tmr_d  = '0;
                    end
                end
                HOLD: begin
                    tmr_d = '0;
                    if (key_valid) begin
                        if (is_digit) begin
                            buf_d     = {12'h000, key_code};
                            cnt_d     = 3'd1;
                            correct_d = 1'b0;
                            state_d   = COLLECT;
                        end else if (is_clear) begin
                            cnt_d     = '0;
                            correct_d = 1'b0;
                            state_d   = COLLECT;
                        end else if (is_cancel) begin
                            buf_d     = '0;
                            cnt_d     = '0;
                            correct_d = 1'b0;
                            cancel_d  = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            correct_q <= 1'b0;
            entered_q <= 1'b0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
            cancel_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            correct_q <= correct_d;
            entered_q <= entered_d;
            err_q     <= err_d;
            tout_q    <= tout_d;
            cancel_q  <= cancel_d;
            active_q  <= state_d == COLLECT;
        end
    end

    assign pin_entered     = entered_q;
    assign pin_correct     = correct_q;
    assign digit_count     = cnt_q;
    assign key_error       = err_q;
    assign entry_timeout   = tout_q;
    assign entry_cancelled = cancel_q;
    assign entry_active    = active_q;
endmodule

// File: tb/tb_pin_entry_keypad.sv
// tb_pin_entry_keypad: directed vector table plus hand-written multi-cycle sequences
// (held verdict, length errors, inactivity timeout, card pull, async reset).
module tb_pin_entry_keypad;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        card_present = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] stored_pin = 16'h1234;
    logic        pin_entered, pin_correct, key_error, entry_timeout, entry_cancelled, entry_active;
    logic [2:0]  digit_count;
    int          n_chk = 0;
    int          n_fail = 0;

    pin_entry_keypad #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .card_present(card_present), .key_valid(key_valid),
        .key_code(key_code), .stored_pin(stored_pin), .pin_entered(pin_entered),
        .pin_correct(pin_correct), .digit_count(digit_count), .key_error(key_error),
        .entry_timeout(entry_timeout), .entry_cancelled(entry_cancelled),
        .entry_active(entry_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cp;
        logic       kv;
        logic [3:0] kc;
        logic [8:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic logic [8:0] e(input logic pe, input logic pc, input logic [2:0] dc,
                                     input logic ke, input logic et, input logic ec,
                                     input logic ea);
        return {pe, pc, dc, ke, et, ec, ea};
    endfunction

    function automatic logic [8:0] outs();
        return {pin_entered, pin_correct, digit_count, key_error, entry_timeout,
                entry_cancelled, entry_active};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        n_chk++;
        if (outs() !== exp) begin
            n_fail++;
            $display("FAIL %s: got pe,pc,dc,ke,et,ec,ea=%b required %b", name, outs(), exp);
        end
    endtask

    task automatic step(input logic cp, input logic kv, input logic [3:0] kc);
        card_present = cp;
        key_valid    = kv;
        key_code     = kc;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic v(input logic cp, input logic kv, input logic [3:0] kc, input logic [8:0] exp);
        vq.push_back('{cp: cp, kv: kv, kc: kc, exp: exp});
    endtask

    initial begin
        v(1, 1, 4'h5, e(0, 0, 0, 0, 0, 0, 1));
        v(1, 1, 4'h1, e(0, 0, 1, 0, 0, 0, 1));
        v(1, 1, 4'h2, e(0, 0, 2, 0, 0, 0, 1));
        v(1, 1, 4'h3, e(0, 0, 3, 0, 0, 0, 1));
        v(1, 1, 4'hB, e(0, 0, 3, 1, 0, 0, 1));
        v(1, 1, 4'h4, e(0, 0, 4, 0, 0, 0, 1));
        v(1, 1, 4'h9, e(0, 0, 4, 1, 0, 0, 1));
        v(1, 1, 4'hE, e(0, 0, 4, 1, 0, 0, 1));
        v(1, 1, 4'hB, e(1, 1, 4, 0, 0, 0, 0));
        v(1, 0, 4'h0, e(0, 1, 4, 0, 0, 0, 0));
        v(1, 1, 4'hB, e(0, 1, 4, 1, 0, 0, 0));
        v(1, 1, 4'h9, e(0, 0, 1, 0, 0, 0, 1));
        v(1, 1, 4'h8, e(0, 0, 2, 0, 0, 0, 1));
        v(1, 1, 4'h7, e(0, 0, 3, 0, 0, 0, 1));
        v(1, 1, 4'h6, e(0, 0, 4, 0, 0, 0, 1));
        v(1, 1, 4'hB, e(1, 0, 4, 0, 0, 0, 0));
        v(1, 1, 4'hA, e(0, 0, 0, 0, 0, 0, 1));
        v(1, 1, 4'h1, e(0, 0, 1, 0, 0, 0, 1));
        v(1, 1, 4'h2, e(0, 0, 2, 0, 0, 0, 1));
        v(1, 1, 4'h3, e(0, 0, 3, 0, 0, 0, 1));
        v(1, 1, 4'h4, e(0, 0, 4, 0, 0, 0, 1));
        v(1, 1, 4'hB, e(1, 1, 4, 0, 0, 0, 0));
        v(1, 1, 4'hC, e(0, 0, 0, 0, 0, 1, 0));
        v(1, 0, 4'h0, e(0, 0, 0, 0, 0, 0, 1));
        v(1, 1, 4'h3, e(0, 0, 1, 0, 0, 0, 1));
        v(1, 1, 4'hA, e(0, 0, 0, 0, 0, 0, 1));
        v(1, 1, 4'h1, e(0, 0, 1, 0, 0, 0, 1));
        v(1, 1, 4'hC, e(0, 0, 0, 0, 0, 1, 0));
        v(0, 0, 4'h0, e(0, 0, 0, 0, 0, 0, 0));
        v(1, 1, 4'h1, e(0, 0, 0, 0, 0, 0, 1));

        #12;
        check("reset_state", e(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_card", e(0, 0, 0, 0, 0, 0, 0));

        foreach (vq[i]) begin
            step(vq[i].cp, vq[i].kv, vq[i].kc);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // Correct PIN held through a long HOLD until the card is pulled.
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 4'(i));
            check("held_digit", e(0, 0, 3'(i), 0, 0, 0, 1));
        end
        step(1, 1, 4'hB);
        check("held_enter", e(1, 1, 4, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 4'h0);
            check("held_hold", e(0, 1, 4, 0, 0, 0, 0));
        end
        step(0, 0, 4'h0);
        check("held_pull", e(0, 0, 0, 0, 0, 0, 0));

        // Length errors: short enter, over-length digit, then the buffer is proven 1234.
        step(1, 0, 4'h0);
        check("len_collect", e(0, 0, 0, 0, 0, 0, 1));
        step(1, 1, 4'h1);
        step(1, 1, 4'h2);
        step(1, 1, 4'hB);
        check("len_short_enter", e(0, 0, 2, 1, 0, 0, 1));
        step(1, 1, 4'h3);
        step(1, 1, 4'h4);
        step(1, 1, 4'h5);
        check("len_fifth_digit", e(0, 0, 4, 1, 0, 0, 1));
        step(1, 1, 4'hB);
        check("len_buf_1234", e(1, 1, 4, 0, 0, 0, 0));
        step(1, 1, 4'hA);
        check("len_clear", e(0, 0, 0, 0, 0, 0, 1));

        // Timeout: fires exactly 8 cycles after the last key.
        step(1, 1, 4'h7);
        step(1, 1, 4'h7);
        check("to_two_digits", e(0, 0, 2, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 4'h0);
            check("to_wait", e(0, 0, 2, 0, 0, 0, 1));
        end
        step(1, 0, 4'h0);
        check("to_fire", e(0, 0, 0, 0, 1, 0, 1));
        step(1, 0, 4'h0);
        check("to_after", e(0, 0, 0, 0, 0, 0, 1));

        // A key landing in the limit cycle wins over the timeout.
        step(1, 1, 4'h7);
        step(1, 1, 4'h7);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 4'h0);
            check("to2_wait", e(0, 0, 2, 0, 0, 0, 1));
        end
        step(1, 1, 4'h7);
        check("to2_key_wins", e(0, 0, 3, 0, 0, 0, 1));
        step(1, 0, 4'h0);
        check("to2_after", e(0, 0, 3, 0, 0, 0, 1));

        // Card pulled in the same cycle as a valid enter.
        step(1, 1, 4'h7);
        check("pull_four", e(0, 0, 4, 0, 0, 0, 1));
        step(0, 1, 4'hB);
        check("pull_enter", e(0, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-cycle while holding a correct verdict.
        step(1, 0, 4'h0);
        for (int i = 1; i <= 4; i++) step(1, 1, 4'(i));
        step(1, 1, 4'hB);
        step(1, 0, 4'h0);
        check("rst_pre", e(0, 1, 4, 0, 0, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", e(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_held", e(0, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
